fifo_status_ctrl: RTL and testbench



---
 rtl/fifo_status_ctrl_if.sv | 47 ++++
 rtl/fifo_status_ctrl.sv | 122 ++++++++++++
 tb/tb_fifo_status_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_status_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_status_ctrl_if
// Bundle between a FIFO's push/pop requesters and its pointer/status controller.
//   master : requester side, drives CLR / WR_EN / RD_EN and observes the rest
//   slave  : controller side, drives accepts, addresses, pointers, count, flags
// Signals:
//   CLR                 synchronous flush request
//   WR_EN, RD_EN        push / pop requests
//   WR_ACC, RD_ACC      push / pop accepted this cycle (combinational)
//   WR_ADDR, RD_ADDR    storage array addresses (ADDR_W bits)
//   WR_PTR, RD_PTR      pointers including the wrap bit (ADDR_W+1 bits)
//   Count               occupancy 0..2^ADDR_W
//   Full, Empty, Almost_Full, Almost_Empty   registered status flags
//   Overflow, Underflow sticky error flags
// -----------------------------------------------------------------------------
interface fifo_status_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              CLR;
    logic              WR_EN;
    logic              RD_EN;
    logic              WR_ACC;
    logic              RD_ACC;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [ADDR_W-1:0] RD_ADDR;
    logic [ADDR_W:0]   WR_PTR;
    logic [ADDR_W:0]   RD_PTR;
    logic [ADDR_W:0]   Count;
    logic              Full;
    logic              Empty;
    logic              Almost_Full;
    logic              Almost_Empty;
    logic              Overflow;
    logic              Underflow;

    modport master (
        output CLR, WR_EN, RD_EN,
        input  WR_ACC, RD_ACC, WR_ADDR, RD_ADDR, WR_PTR, RD_PTR, Count,
               Full, Empty, Almost_Full, Almost_Empty, Overflow, Underflow
    );

    modport slave (
        input  CLR, WR_EN, RD_EN,
        output WR_ACC, RD_ACC, WR_ADDR, RD_ADDR, WR_PTR, RD_PTR, Count,
               Full, Empty, Almost_Full, Almost_Empty, Overflow, Underflow
    );
endinterface

// File: rtl/fifo_status_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_status_ctrl
// Pointer and status controller for a power-of-two-deep, single-clock FIFO.
// Pointers carry an extra wrap bit; Full/Empty and the almost flags are
// registered from the next-state occupancy so they line up with the pointers.
// Ports:
//   CLK   clock, all state updates on the rising edge
//   RST   synchronous active-high reset
//   bus   fifo_status_ctrl_if.slave (flush, push/pop requests and accepts,
//         storage addresses, pointers, count, status and sticky error flags)
// Parameters:
//   ADDR_W    address width, depth = 2^ADDR_W
//   AF_LEVEL  Almost_Full when Count >= AF_LEVEL (1..2^ADDR_W)
//   AE_LEVEL  Almost_Empty when Count <= AE_LEVEL (0..2^ADDR_W-1)
// -----------------------------------------------------------------------------
module fifo_status_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int AF_LEVEL = 2**ADDR_W - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              CLK,
    input  logic              RST,
    fifo_status_ctrl_if.slave bus
);
    localparam int              DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);
    localparam logic            AF_RST  = (AF_LEVEL == 0);

    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
        $error("fifo_status_ctrl: AF_LEVEL %0d outside 1..%0d", AF_LEVEL, DEPTH);
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae_level
        $error("fifo_status_ctrl: AE_LEVEL %0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
    end

    function automatic logic flag_full(input logic [ADDR_W:0] cnt);
        return cnt == DEPTH_C;
    endfunction

    function automatic logic flag_af(input logic [ADDR_W:0] cnt);
        return cnt >= AF_C;
    endfunction

    function automatic logic flag_ae(input logic [ADDR_W:0] cnt);
        return cnt <= AE_C;
    endfunction

    logic            flush;
    logic            wr_acc;
    logic            rd_acc;
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] count_q,  count_d;
    logic            full_q,   full_d;
    logic            empty_q,  empty_d;
    logic            af_q,     af_d;
    logic            ae_q,     ae_d;
    logic            ovf_q,    ovf_d;
    logic            unf_q,    unf_d;

    always_comb begin
        flush  = RST | bus.CLR;
        // Accepts look only at registered flags, so no enable reaches a
        // registered output combinationally.
        wr_acc = bus.WR_EN & ~full_q  & ~flush;
        rd_acc = bus.RD_EN & ~empty_q & ~flush;

        // Natural (ADDR_W+1)-bit wrap gives the modulo 2^(ADDR_W+1) increment.
        wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, wr_acc};
        rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, rd_acc};
        count_d  = count_q + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, rd_acc};

        // Flags come from next-state count so they are valid with the pointers.
        full_d  = flag_full(count_d);
        empty_d = (count_d == '0);
        af_d    = flag_af(count_d);
        ae_d    = flag_ae(count_d);

        ovf_d   = ovf_q | (bus.WR_EN & full_q);
        unf_d   = unf_q | (bus.RD_EN & empty_q);
    end

    always_ff @(posedge CLK) begin
        if (RST || bus.CLR) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= AF_RST;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign bus.WR_ACC       = wr_acc;
    assign bus.RD_ACC       = rd_acc;
    assign bus.WR_ADDR      = wr_ptr_q[ADDR_W-1:0];
    assign bus.RD_ADDR      = rd_ptr_q[ADDR_W-1:0];
    assign bus.WR_PTR       = wr_ptr_q;
    assign bus.RD_PTR       = rd_ptr_q;
    assign bus.Count        = count_q;
    assign bus.Full         = full_q;
    assign bus.Empty        = empty_q;
    assign bus.Almost_Full  = af_q;
    assign bus.Almost_Empty = ae_q;
    assign bus.Overflow     = ovf_q;
    assign bus.Underflow    = unf_q;
endmodule

// File: tb/tb_fifo_status_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_status_ctrl
// Scoreboard bench for fifo_status_ctrl with ADDR_W=3, AF_LEVEL=6, AE_LEVEL=2.
// Each cycle the driver computes the expected post-edge state from a small
// occupancy model, pushes it to a queue, and the monitor pops and compares it
// one cycle later. Directed scenarios are followed by a random regression.
// -----------------------------------------------------------------------------
module tb_fifo_status_ctrl;
    localparam int ADDR_W = 3;
    localparam int AF     = 6;
    localparam int AE     = 2;
    localparam int DEPTH  = 8;
    localparam int PMOD   = 16;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    fifo_status_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    fifo_status_ctrl #(
        .ADDR_W  (ADDR_W),
        .AF_LEVEL(AF),
        .AE_LEVEL(AE)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    typedef struct {
        int unsigned wptr;
        int unsigned rptr;
        int unsigned cnt;
        bit          full;
        bit          empty;
        bit          af;
        bit          ae;
        bit          ovf;
        bit          unf;
    } exp_t;

    exp_t sb_q[$];

    int unsigned m_wptr = 0;
    int unsigned m_rptr = 0;
    int unsigned m_cnt  = 0;
    bit          m_ovf  = 0;
    bit          m_unf  = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic monitor_cmp();
        exp_t        e;
        int unsigned c;
        if (sb_q.size() == 0) begin
            chk("sb_underrun", 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk("wr_ptr", bus.WR_PTR,       e.wptr);
            chk("rd_ptr", bus.RD_PTR,       e.rptr);
            chk("count",  bus.Count,        e.cnt);
            chk("full",   bus.Full,         e.full);
            chk("empty",  bus.Empty,        e.empty);
            chk("afull",  bus.Almost_Full,  e.af);
            chk("aempty", bus.Almost_Empty, e.ae);
            chk("ovf",    bus.Overflow,     e.ovf);
            chk("unf",    bus.Underflow,    e.unf);
        end
        c = 32'(bus.Count);
        chk("inv_cnt_ptr", bus.Count, (32'(bus.WR_PTR) - 32'(bus.RD_PTR)) % PMOD);
        chk("inv_full_empty", 32'(bus.Full) + 32'(bus.Empty),
            (c == 0 || c == DEPTH) ? 1 : 0);
    endtask

    // One clock: drive at negedge, check accepts, predict, compare after posedge.
    task automatic step(input bit wr, input bit rd, input bit clr, input bit rst);
        exp_t e;
        bit   mfull, mempty, wa, ra;
        RST       = rst;
        bus.CLR   = clr;
        bus.WR_EN = wr;
        bus.RD_EN = rd;
        mfull  = (m_cnt == DEPTH);
        mempty = (m_cnt == 0);
        wa = wr && !mfull  && !rst && !clr;
        ra = rd && !mempty && !rst && !clr;
        #1;
        chk("wr_acc", bus.WR_ACC, wa);
        chk("rd_acc", bus.RD_ACC, ra);
        if (!rst) begin
            chk("wr_addr", bus.WR_ADDR, m_wptr % DEPTH);
            chk("rd_addr", bus.RD_ADDR, m_rptr % DEPTH);
        end
        if (rst || clr) begin
            m_wptr = 0; m_rptr = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
        end else begin
            if (wr && mfull)  m_ovf = 1;
            if (rd && mempty) m_unf = 1;
            m_wptr = (m_wptr + 32'(wa)) % PMOD;
            m_rptr = (m_rptr + 32'(ra)) % PMOD;
            m_cnt  = m_cnt + 32'(wa) - 32'(ra);
        end
        e.wptr  = m_wptr;
        e.rptr  = m_rptr;
        e.cnt   = m_cnt;
        e.full  = (m_cnt == DEPTH);
        e.empty = (m_cnt == 0);
        e.af    = (m_cnt >= AF);
        e.ae    = (m_cnt <= AE);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        monitor_cmp();
        @(negedge CLK);
    endtask

    initial begin
        bus.CLR   = 1'b0;
        bus.WR_EN = 1'b0;
        bus.RD_EN = 1'b0;
        @(negedge CLK);

        // Reset
        step(0, 0, 0, 1);
        chk("rst_empty",  bus.Empty,        1);
        chk("rst_aempty", bus.Almost_Empty, 1);
        chk("rst_full",   bus.Full,         0);
        chk("rst_afull",  bus.Almost_Full,  0);
        chk("rst_count",  bus.Count,        0);
        chk("rst_wptr",   bus.WR_PTR,       0);
        chk("rst_rptr",   bus.RD_PTR,       0);
        chk("rst_ovf",    bus.Overflow,     0);
        chk("rst_unf",    bus.Underflow,    0);

        // Fill
        for (int i = 1; i <= DEPTH; i++) begin
            step(1, 0, 0, 0);
            if (i == 2) chk("fill2_aempty", bus.Almost_Empty, 1);
            if (i == 3) chk("fill3_aempty", bus.Almost_Empty, 0);
            if (i == 5) chk("fill5_afull",  bus.Almost_Full,  0);
            if (i == 6) chk("fill6_afull",  bus.Almost_Full,  1);
        end
        chk("fill_full",  bus.Full,   1);
        chk("fill_count", bus.Count,  8);
        chk("fill_wptr",  bus.WR_PTR, 4'b1000);
        step(1, 0, 0, 0);
        chk("push9_wptr", bus.WR_PTR,   4'b1000);
        chk("push9_ovf",  bus.Overflow, 1);

        // Drain
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0);
        chk("drain_empty", bus.Empty,  1);
        chk("drain_count", bus.Count,  0);
        chk("drain_rptr",  bus.RD_PTR, 4'b1000);
        step(0, 1, 0, 0);
        chk("pop9_unf",    bus.Underflow, 1);
        chk("pop9_ovf",    bus.Overflow,  1);
        chk("pop9_rptr",   bus.RD_PTR,    4'b1000);

        // Simultaneous at Count=4 across pointer wrap
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0);
        chk("sim_count", bus.Count,  4);
        chk("sim_wptr",  bus.WR_PTR, 4'd0);
        chk("sim_rptr",  bus.RD_PTR, 4'd12);

        // Simultaneous at Full
        step(0, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("simfull_count", bus.Count,    7);
        chk("simfull_full",  bus.Full,     0);
        chk("simfull_ovf",   bus.Overflow, 1);

        // Simultaneous at Empty
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("simempty_count", bus.Count,     1);
        chk("simempty_empty", bus.Empty,     0);
        chk("simempty_unf",   bus.Underflow, 1);

        // Flush mid-stream at Count=5
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        chk("preflush_count", bus.Count, 5);
        step(1, 0, 1, 0);
        chk("flush_count", bus.Count,     0);
        chk("flush_empty", bus.Empty,     1);
        chk("flush_ovf",   bus.Overflow,  0);
        chk("flush_unf",   bus.Underflow, 0);
        chk("flush_wptr",  bus.WR_PTR,    0);

        // Random regression with biased phases to reach both boundaries
        for (int i = 0; i < 10000; i++) begin
            int unsigned bias;
            bit          w, r, c;
            bias = (i / 64) % 3;
            case (bias)
                0:       begin w = ($urandom_range(99) < 80); r = ($urandom_range(99) < 30); end
                1:       begin w = ($urandom_range(99) < 30); r = ($urandom_range(99) < 80); end
                default: begin w = $urandom_range(1) == 1;    r = $urandom_range(1) == 1;    end
            endcase
            c = ($urandom_range(499) == 0);
            step(w, r, c, 0);
        end

        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
